// File: rtl/matrix_pkg.sv
// matrix_pkg: shared defaults, FSM state type, beat count and saturation bounds for matrix_elemwise_stream
package matrix_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int ROWS_DEF    = 32;
  localparam int COLS_DEF    = 10;
  localparam int LANES_DEF   = 10;
  localparam int SHIFT_W_DEF = 5;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int beat_count(int rows, int cols, int lanes);
    return rows * cols / lanes;
  endfunction
  function automatic longint sat_max(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic longint sat_min(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/elem_op_lane.sv
// elem_op_lane: one lane of c = a op (b >>> shift); ports a, b, shift, sub -> c (+ sat when MATRIX_ELEMWISE_SAT_EN)
module elem_op_lane
  import matrix_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
)(
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [DATA_W-1:0]  b,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      sub,
  output logic signed [DATA_W-1:0]  c
`ifdef MATRIX_ELEMWISE_SAT_EN
  ,
  output logic                      sat
`endif
);
  logic signed [DATA_W-1:0] bs;
  assign bs = b >>> shift;
`ifdef MATRIX_ELEMWISE_SAT_EN
  localparam logic signed [DATA_W:0] HI = (DATA_W+1)'(sat_max(DATA_W));
  localparam logic signed [DATA_W:0] LO = (DATA_W+1)'(sat_min(DATA_W));
  logic signed [DATA_W:0] ax, bx, r;
  assign ax  = {a[DATA_W-1], a};
  assign bx  = {bs[DATA_W-1], bs};
  assign r   = sub ? ax - bx : ax + bx;
  assign sat = (r > HI) | (r < LO);
  assign c   = (r > HI) ? HI[DATA_W-1:0] : (r < LO) ? LO[DATA_W-1:0] : r[DATA_W-1:0];
`else
  assign c = sub ? a - bs : a + bs;
`endif
endmodule

// File: rtl/matrix_elemwise_stream.sv
// matrix_elemwise_stream: streams C = A op (B >>> b_shift) over a ROWS x COLS matrix, LANES elements per beat
// Ports: clk, rst (sync, active high); start/op_sub/b_shift (latched in IDLE), busy, done;
// input stream in_valid/in_ready/a_data/b_data; output stream out_valid/out_ready/c_data/out_last/beat_idx.
// Option MATRIX_ELEMWISE_SAT_EN: per-lane clamping plus sticky sat_flag output.
module matrix_elemwise_stream
  import matrix_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  localparam int BEATS  = beat_count(ROWS, COLS, LANES),
  localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [SHIFT_W-1:0]        b_shift,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   a_data,
  input  logic [LANES*DATA_W-1:0]   b_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   c_data,
  output logic                      out_last,
  output logic [IW-1:0]             beat_idx
`ifdef MATRIX_ELEMWISE_SAT_EN
  ,
  output logic                      sat_flag
`endif
);
  if ((ROWS * COLS) % LANES != 0) begin : g_bad_lanes
    $error("ROWS*COLS must be divisible by LANES");
  end
  localparam logic [IW-1:0] LAST = IW'(BEATS - 1);
  state_t               state;
  logic [IW-1:0]        in_cnt;
  logic                 op_r;
  logic [SHIFT_W-1:0]   shift_r;
  logic [LANES*DATA_W-1:0] res;
  logic                 in_acc, out_acc;
`ifdef MATRIX_ELEMWISE_SAT_EN
  logic [LANES-1:0]     lane_sat;
`endif
  assign in_ready = (state == RUN) & (~out_valid | out_ready);
  assign in_acc   = in_valid & in_ready;
  assign out_acc  = out_valid & out_ready;
  assign out_last = out_valid & (beat_idx == LAST);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    elem_op_lane #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) u_lane (
      .a     (a_data[(LANES-g)*DATA_W-1 -: DATA_W]),
      .b     (b_data[(LANES-g)*DATA_W-1 -: DATA_W]),
      .shift (shift_r),
      .sub   (op_r),
      .c     (res[(LANES-g)*DATA_W-1 -: DATA_W])
`ifdef MATRIX_ELEMWISE_SAT_EN
      ,
      .sat   (lane_sat[g])
`endif
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_cnt    <= '0;
      beat_idx  <= '0;
      op_r      <= 1'b0;
      shift_r   <= '0;
      out_valid <= 1'b0;
      c_data    <= '0;
`ifdef MATRIX_ELEMWISE_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (in_acc) begin
        out_valid <= 1'b1;
        c_data    <= res;
      end else if (out_acc) begin
        out_valid <= 1'b0;
      end
      if (out_acc) beat_idx <= (beat_idx == LAST) ? '0 : beat_idx + 1'b1;
`ifdef MATRIX_ELEMWISE_SAT_EN
      if (in_acc & |lane_sat) sat_flag <= 1'b1;
`endif
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          op_r    <= op_sub;
          shift_r <= b_shift;
          in_cnt  <= '0;
`ifdef MATRIX_ELEMWISE_SAT_EN
          sat_flag <= 1'b0;
`endif
        end
        RUN: if (in_acc) begin
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt == LAST) state <= DRAIN;
        end
        DRAIN: if (out_acc & out_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_elemwise_stream.sv
// tb_matrix_elemwise_stream: table-driven and randomized checks of matrix_elemwise_stream against an arithmetic model
module tb_matrix_elemwise_stream;
  localparam int DW = 32, L = 10, NB = 32, NE = 320;
  localparam longint HI = 64'sd2147483647;
  localparam longint LO = -64'sd2147483648;
`ifdef MATRIX_ELEMWISE_SAT_EN
  localparam logic [31:0] OVF_EXP = 32'h7FFFFFFF;
`else
  localparam logic [31:0] OVF_EXP = 32'h80000000;
`endif
  logic clk = 0, rst = 1, start = 0, op_sub = 0, in_valid = 0, out_ready = 0;
  logic [4:0] b_shift = 0;
  logic busy, done, in_ready, out_valid, out_last;
  logic [L*DW-1:0] a_data = '0, b_data = '0, c_data;
  logic [4:0] beat_idx;
`ifdef MATRIX_ELEMWISE_SAT_EN
  logic sat_flag;
`endif
  always #5 clk = ~clk;
  matrix_elemwise_stream dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .b_shift(b_shift),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready),
    .c_data(c_data), .out_last(out_last), .beat_idx(beat_idx)
`ifdef MATRIX_ELEMWISE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] ma [NE], mb [NE], mc [NE];
  bit exp_sat;
  logic [DW-1:0] first_c, last_c;
  typedef struct {
    int pat; bit sub; int sh; int vmode; int rmode; bit poke; bit has_c; logic [31:0] expc;
  } vec_t;
  vec_t vec [6];
  task automatic chk(input string name, input logic [L*DW-1:0] got, input logic [L*DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic fill(input int pat);
    for (int i = 0; i < NE; i++) begin
      case (pat)
        0: begin ma[i] = 32'(100 + i); mb[i] = 32'(i); end
        1: begin ma[i] = 32'd0; mb[i] = 32'hFFFFFFEF; end
        2: begin ma[i] = $urandom; mb[i] = $urandom; end
        default: begin ma[i] = 32'h7FFFFFFF; mb[i] = 32'hFFFFFFFF; end
      endcase
    end
  endtask
  task automatic build_model(input bit sub, input int sh);
    longint a, b, bs, r;
    exp_sat = 0;
    for (int i = 0; i < NE; i++) begin
      a  = signed'(ma[i]);
      b  = signed'(mb[i]);
      bs = b >>> sh;
      r  = sub ? a - bs : a + bs;
`ifdef MATRIX_ELEMWISE_SAT_EN
      if (r > HI) begin r = HI; exp_sat = 1; end
      else if (r < LO) begin r = LO; exp_sat = 1; end
`endif
      mc[i] = r[31:0];
    end
  endtask
  task automatic run_matrix(input bit sub, input int sh, input int vmode, input int rmode,
                            input bit poke, input int stop_at);
    int ib = 0, ob = 0, cyc = 0;
    bit held = 0;
    logic [L*DW-1:0] hc, ev;
    logic [4:0] hidx;
    build_model(sub, sh);
    @(negedge clk);
    start = 1; op_sub = sub; b_shift = sh[4:0];
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    while (ob < stop_at && cyc < 3000) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc[0] == 1'b0) : 1'($urandom_range(0, 1));
      in_valid  = (ib < NB) && (vmode == 0 || $urandom_range(0, 1) == 1);
      start     = poke && cyc == 5;
      op_sub    = (poke && cyc == 5) ? !sub : sub;
      for (int l = 0; l < L; l++) begin
        if (in_valid) begin
          a_data[(L-l)*DW-1 -: DW] = ma[ib*L+l];
          b_data[(L-l)*DW-1 -: DW] = mb[ib*L+l];
        end else begin
          a_data[(L-l)*DW-1 -: DW] = $urandom;
          b_data[(L-l)*DW-1 -: DW] = $urandom;
        end
      end
      #1;
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", c_data, hc);
        chk("stall_idx", beat_idx, hidx);
      end
      held = out_valid && !out_ready;
      hc = c_data;
      hidx = beat_idx;
      if (out_valid && out_ready) begin
        for (int l = 0; l < L; l++) ev[(L-l)*DW-1 -: DW] = mc[ob*L+l];
        chk($sformatf("beat%0d_data", ob), c_data, ev);
        chk($sformatf("beat%0d_idx", ob), beat_idx, ob[4:0]);
        chk($sformatf("beat%0d_last", ob), out_last, ob == NB - 1);
        if (ob == 0) first_c = c_data[L*DW-1 -: DW];
        if (ob == NB - 1) last_c = c_data[DW-1:0];
        ob++;
      end
      if (in_valid && in_ready) ib++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 0;
    start = 0;
    if (ob < stop_at) begin
      n_chk++;
      $display("FAIL timeout: got %0d beats required %0d", ob, stop_at);
    end
    if (stop_at == NB) begin
      if (vmode == 0 && rmode == 0) chk("throughput_cycles", cyc, NB + 1);
      chk("done_pulse", done, 1);
      chk("busy_low_at_done", busy, 0);
      chk("valid_low_at_done", out_valid, 0);
`ifdef MATRIX_ELEMWISE_SAT_EN
      chk("sat_flag", sat_flag, exp_sat);
`endif
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_beat_idx"}, beat_idx, 0);
    chk({tag, "_c_data"}, c_data, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0] = '{0, 1'b1, 0,  0, 0, 1'b0, 1'b1, 32'd100};
    vec[1] = '{1, 1'b0, 3,  0, 0, 1'b0, 1'b1, 32'hFFFFFFFD};
    vec[2] = '{2, 1'b1, 7,  1, 1, 1'b0, 1'b0, 32'd0};
    vec[3] = '{3, 1'b1, 0,  0, 2, 1'b0, 1'b1, OVF_EXP};
    vec[4] = '{2, 1'b0, 31, 1, 2, 1'b0, 1'b0, 32'd0};
    vec[5] = '{2, 1'b1, 0,  1, 0, 1'b1, 1'b0, 32'd0};
    rst = 1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;
    for (int t = 0; t < 6; t++) begin
      fill(vec[t].pat);
      run_matrix(vec[t].sub, vec[t].sh, vec[t].vmode, vec[t].rmode, vec[t].poke, NB);
      if (vec[t].has_c) begin
        chk($sformatf("vec%0d_first_elem", t), first_c, vec[t].expc);
        chk($sformatf("vec%0d_last_elem", t), last_c, vec[t].expc);
      end
    end
    fill(2);
    run_matrix(1'b1, 2, 0, 0, 1'b0, 12);
    rst = 1;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
    end
    fill(2);
    run_matrix(1'b0, 1, 1, 2, 1'b0, NB);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
